softmax_out_writer: RTL and testbench
=====================================

# softmax_out_writer

Write-back stage directly downstream of the softmax pipeline. Captures each `NUM`-lane result beat produced while the softmax `done` strobe is high and buffers it in a small FIFO. Writes the beats as packed words into the on-chip output memory, starting at a latched base address and using a memory-side ready handshake. Signals completion once the expected number of words (`end_addr - start_addr`) has been written.

## Interface
- `DATAWIDTH`, 32, width of one lane
- `NUM`, 2, lanes per beat
- `ADDRSIZE`, 9, memory address width
- `FIFO_DEPTH`, 4, beat buffer depth (power of two, ≥2)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `init` in 1: pulse; latches `out_base_addr`, `start_addr` and `end_addr`, then arms the block
- `out_base_addr` in `ADDRSIZE`: first output memory address
- `start_addr`, `end_addr` in `ADDRSIZE`: same values given to softmax; expected words = `end_addr - start_addr` (unsigned, modulo 2^ADDRSIZE)
- `in_valid` in 1: softmax `done` strobe; one beat per high cycle
- `in_data0`, `in_data1` in `DATAWIDTH`: softmax `outp0`, `outp1`
- `wr_en` out 1: write request
- `wr_addr` out `ADDRSIZE`: write address
- `wr_data` out `DATAWIDTH*NUM`: lane0 in bits `[DATAWIDTH-1:0]`, lane1 above it
- `wr_ready` in 1: memory accepts the write this cycle
- `busy` out 1: high in RUN
- `complete` out 1: one-cycle pulse when all expected words are written
- `overflow` out 1: sticky flag; a beat was lost to a full FIFO; cleared by `init` or reset

## Operation
- States:
  - IDLE: `init` → RUN. If the expected count is 0, `init` → DONE instead.
  - RUN: accepts and writes beats; → DONE in the cycle after the last write handshake.
  - DONE: `complete`=1 for one cycle; → IDLE.
- On `init` (in IDLE or DONE):
  - `wr_addr` ← `out_base_addr`
  - `remaining` ← `end_addr - start_addr`
  - `accepted` ← 0
  - FIFO flushed
  - `overflow` ← 0
- `init` while in RUN is ignored.
- Push: `in_valid` in RUN, with `accepted` < expected and the FIFO not full (or full with a pop in the same cycle). The push increments `accepted`.
- Beat lost: `in_valid` in RUN with the FIFO full and no pop → beat dropped, `overflow` ← 1.
- Beats arriving once `accepted` = expected, or arriving outside RUN, are dropped silently with no flag.
- `wr_en` = RUN && FIFO not empty; `wr_data` is the FIFO head.
- Handshake: a write completes on `wr_en && wr_ready`. On that cycle the FIFO pops, `wr_addr` increments, and `remaining` decrements.
- `wr_addr` wraps from 2^ADDRSIZE−1 to 0.
- While `wr_en` is high without `wr_ready`, `wr_addr` and `wr_data` must hold stable.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `complete`=0, `overflow`=0, state IDLE, FIFO empty.
- Reset asserted mid-operation aborts the transfer. No `complete` is issued.

## Timing
- `in_valid` at cycle N → `wr_en` high at N+1 (the FIFO is registered; there is no bypass).
- Sustained throughput is 1 beat/cycle when `wr_ready`=1.
- Last handshake at cycle M → `complete` at M+1 and `busy` low at M+1.
- With `wr_ready`=1, a simultaneous push and pop leaves the FIFO occupancy unchanged.
- Because softmax cannot stall, `FIFO_DEPTH` covers at most `FIFO_DEPTH` cycles of `wr_ready`=0 during a burst.

## Configuration
- `SMAX_OUT_CLAMP_EN` defined: each lane is checked at push time. A lane with its MSB set (negative fixed-point value from exp wrap) is stored as 0.
- `SMAX_OUT_CLAMP_EN` undefined: lanes are stored unmodified.

## Structure
- Shared package `softmax_pkg`: `DATAWIDTH`, `NUM`, `ADDRSIZE` constants, the beat typedef (`NUM`×`DATAWIDTH`), and the writer state enum (IDLE/RUN/DONE).
- Sub-module `softmax_out_fifo`: synchronous FIFO with async active-low reset, `FIFO_DEPTH`×`DATAWIDTH*NUM`, and full/empty flags. It allows a push while full when a pop occurs in the same cycle.

## Test plan
- Basic run:
  - Stimulus: base=0x010, start=0, end=4, `wr_ready`=1, 4 consecutive beats (0x00000100/0x00000200 …).
  - Response: writes at 0x010–0x013, each one cycle after its beat; `complete` one cycle after the 0x013 write; `overflow`=0.
- Backpressure:
  - Stimulus: `wr_ready`=0 for 3 cycles during a 4-beat burst.
  - Response: no loss; `wr_addr`/`wr_data` stable while stalled; 4 writes in order.
- Overflow:
  - Stimulus: `FIFO_DEPTH`=4, `wr_ready`=0, 6 beats.
  - Response: 4 beats written after `wr_ready` rises, `overflow`=1, no `complete`.
- Wrap and zero count:
  - Stimulus: base=0x1FF with 2 beats; then a second `init` with start=end.
  - Response: writes at 0x1FF then 0x000; the zero-count `init` gives `complete` at `init`+1 with no `wr_en`.
- Reset mid-run:
  - Stimulus: `reset` low after 2 of 4 writes.
  - Response: all outputs return to reset values immediately; no `complete`.
- Clamp:
  - Stimulus: with `SMAX_OUT_CLAMP_EN`, beat lane0=0x80000010.
  - Response: `wr_data` lane0=0. Without the macro: 0x80000010.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax datapath and its output writer.
package softmax_pkg;

    localparam int unsigned DATAWIDTH      = 32;
    localparam int unsigned NUM            = 2;
    localparam int unsigned ADDRSIZE       = 9;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // One result beat: lane 0 occupies the least significant DATAWIDTH bits.
    typedef logic [NUM-1:0][DATAWIDTH-1:0] beat_t;

    // Output writer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_e;

    // A lane with its MSB set is a negative fixed-point value (exp wrap-around).
    function automatic logic lane_negative(input logic [DATAWIDTH-1:0] lane);
        return lane[DATAWIDTH-1];
    endfunction

endpackage

// File: rtl/softmax_out_fifo.sv
// Beat buffer between the softmax pipeline and the output memory port.
// A push while full is accepted when a pop happens in the same cycle.
module softmax_out_fifo
    import softmax_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  beat_t         din,
    input  logic          pop,
    output beat_t         dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    beat_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    // Occupancy flags and effective handshakes.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Head of the queue is presented directly from storage.
    assign dout = mem[rd_ptr];

    // Pointer, occupancy and storage update; flush empties without clearing storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/softmax_out_writer.sv
// Softmax write-back stage: buffers result beats and writes them as packed
// words into the output memory from a latched base address, then pulses
// complete once end_addr - start_addr words have been written.
// Optional build macro SMAX_OUT_CLAMP_EN: lanes with the MSB set are stored as 0.
module softmax_out_writer
    import softmax_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [ADDRSIZE-1:0]      out_base_addr,
    input  logic [ADDRSIZE-1:0]      start_addr,
    input  logic [ADDRSIZE-1:0]      end_addr,
    input  logic                     in_valid,
    input  logic [DATAWIDTH-1:0]     in_data0,
    input  logic [DATAWIDTH-1:0]     in_data1,
    output logic                     wr_en,
    output logic [ADDRSIZE-1:0]      wr_addr,
    output logic [DATAWIDTH*NUM-1:0] wr_data,
    input  logic                     wr_ready,
    output logic                     busy,
    output logic                     complete,
    output logic                     overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]          state_q;
    logic [1:0]          state_n;
    logic [ADDRSIZE-1:0] addr_n;
    logic [ADDRSIZE-1:0] rem_q;
    logic [ADDRSIZE-1:0] rem_n;
    logic [ADDRSIZE-1:0] exp_q;
    logic [ADDRSIZE-1:0] exp_n;
    logic [ADDRSIZE-1:0] acc_q;
    logic [ADDRSIZE-1:0] acc_n;
    logic [ADDRSIZE-1:0] word_cnt;
    logic                ovf_n;
    logic                wr_en_n;
    logic                busy_n;
    logic                complete_n;
    logic [CW-1:0]       count_n;

    logic                init_ok;
    logic                pop;
    logic                take;
    logic                lost;
    logic                fifo_push;
    logic                fifo_flush;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    beat_t               beat_in;
    beat_t               fifo_dout;

    // Handshake qualifiers shared by the control logic and the FIFO.
    assign word_cnt  = end_addr - start_addr;
    assign init_ok   = init && (state_q != S_RUN);
    assign pop       = wr_en && wr_ready;
    assign take      = in_valid && (state_q == S_RUN) && (acc_q < exp_q);
    assign fifo_push = take && (!fifo_full || pop);
    assign lost      = take && fifo_full && !pop;

    // Lane packing, with optional clamping of wrapped negative results.
    always_comb begin
        beat_in[0] = in_data0;
        beat_in[1] = in_data1;
`ifdef SMAX_OUT_CLAMP_EN
        for (int i = 0; i < int'(NUM); i++) begin
            if (lane_negative(beat_in[i])) begin
                beat_in[i] = '0;
            end
        end
`endif
    end

    softmax_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (beat_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Memory data is the FIFO head; it only moves on a completed write.
    assign wr_data = fifo_dout;

    // Next-state, counters and look-ahead for the registered outputs.
    always_comb begin
        state_n    = state_q;
        addr_n     = wr_addr;
        rem_n      = rem_q;
        exp_n      = exp_q;
        acc_n      = acc_q;
        ovf_n      = overflow;
        fifo_flush = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (init_ok) begin
                    addr_n     = out_base_addr;
                    rem_n      = word_cnt;
                    exp_n      = word_cnt;
                    acc_n      = '0;
                    ovf_n      = 1'b0;
                    fifo_flush = 1'b1;
                    state_n    = (word_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop) begin
                    addr_n = wr_addr + ADDRSIZE'(1);
                    rem_n  = rem_q - ADDRSIZE'(1);
                    if (rem_q == ADDRSIZE'(1)) begin
                        state_n = S_DONE;
                    end
                end
                if (fifo_push) begin
                    acc_n = acc_q + ADDRSIZE'(1);
                end
                if (lost) begin
                    ovf_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        count_n    = fifo_flush ? '0 : (fifo_count + CW'(fifo_push) - CW'(pop));
        wr_en_n    = (state_n == S_RUN) && (count_n != '0);
        busy_n     = (state_n == S_RUN);
        complete_n = (state_n == S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_addr  <= '0;
            rem_q    <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            overflow <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            complete <= 1'b0;
        end else begin
            state_q  <= state_n;
            wr_addr  <= addr_n;
            rem_q    <= rem_n;
            exp_q    <= exp_n;
            acc_q    <= acc_n;
            overflow <= ovf_n;
            wr_en    <= wr_en_n;
            busy     <= busy_n;
            complete <= complete_n;
        end
    end

endmodule

// File: tb/tb_softmax_out_writer.sv
// Scoreboard bench for softmax_out_writer: stimulus queues expected writes,
// a negedge monitor pops and compares on every memory handshake.
module tb_softmax_out_writer;
    import softmax_pkg::*;

    typedef struct packed {
        logic [ADDRSIZE-1:0]      addr;
        logic [DATAWIDTH*NUM-1:0] data;
    } wr_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     init = 1'b0;
    logic [ADDRSIZE-1:0]      out_base_addr = '0;
    logic [ADDRSIZE-1:0]      start_addr = '0;
    logic [ADDRSIZE-1:0]      end_addr = '0;
    logic                     in_valid = 1'b0;
    logic [DATAWIDTH-1:0]     in_data0 = '0;
    logic [DATAWIDTH-1:0]     in_data1 = '0;
    logic                     wr_ready = 1'b1;
    logic                     wr_en;
    logic [ADDRSIZE-1:0]      wr_addr;
    logic [DATAWIDTH*NUM-1:0] wr_data;
    logic                     busy;
    logic                     complete;
    logic                     overflow;

    int  checks = 0;
    int  failures = 0;
    int  exp_cmpl = 0;
    bit  zero_mode = 1'b0;
    wr_t exp_q[$];

    softmax_out_writer #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .out_base_addr (out_base_addr),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
        .in_valid      (in_valid),
        .in_data0      (in_data0),
        .in_data1      (in_data1),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .complete      (complete),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference packing of one beat, including the optional clamp.
    function automatic logic [63:0] model(input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] a;
        logic [31:0] b;
        a = d0;
        b = d1;
`ifdef SMAX_OUT_CLAMP_EN
        if (a[31]) a = '0;
        if (b[31]) b = '0;
`endif
        return {b, a};
    endfunction

    task automatic do_init(input logic [8:0] base, input logic [8:0] s, input logic [8:0] e);
        init          = 1'b1;
        out_base_addr = base;
        start_addr    = s;
        end_addr      = e;
        tick();
        init = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d0, input logic [31:0] d1,
                        input bit expect_wr, input logic [8:0] addr);
        wr_t e;
        in_valid = 1'b1;
        in_data0 = d0;
        in_data1 = d1;
        if (expect_wr) begin
            e.addr = addr;
            e.data = model(d0, d1);
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_cmpl != 0) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_cmpl != 0) begin
            failures++;
            $display("FAIL %s_timeout: pending_writes=%0d pending_complete=%0d after %0d cycles",
                     name, exp_q.size(), exp_cmpl, n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_complete"}, 64'(complete), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    // Monitor: write handshakes, stall stability and complete timing.
    initial begin
        bit                       hs_prev;
        bit                       stall_prev;
        logic [ADDRSIZE-1:0]      st_addr;
        logic [DATAWIDTH*NUM-1:0] st_data;
        wr_t                      e;
        hs_prev    = 1'b0;
        stall_prev = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hs_prev    = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (complete) begin
                    checks++;
                    if (exp_cmpl == 0 || (!zero_mode && (!hs_prev || exp_q.size() != 0))) begin
                        failures++;
                        $display("FAIL complete_pulse: complete=1 pending_complete=%0d prev_handshake=%0b queued=%0d",
                                 exp_cmpl, hs_prev, exp_q.size());
                    end
                    if (exp_cmpl > 0) exp_cmpl--;
                end
                if (wr_en && wr_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: addr=0x%0h data=0x%0h none expected", wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (wr_addr !== e.addr || wr_data !== e.data) begin
                            failures++;
                            $display("FAIL write_compare: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                                     wr_addr, wr_data, e.addr, e.data);
                        end
                    end
                end
                if (stall_prev && wr_en) begin
                    checks++;
                    if (wr_addr !== st_addr || wr_data !== st_data) begin
                        failures++;
                        $display("FAIL stall_stable: got addr=0x%0h data=0x%0h held addr=0x%0h data=0x%0h",
                                 wr_addr, wr_data, st_addr, st_data);
                    end
                end
                stall_prev = wr_en && !wr_ready;
                st_addr    = wr_addr;
                st_data    = wr_data;
                hs_prev    = wr_en && wr_ready;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #2;
        chk_reset_vals("por");
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Basic run: 4 beats to 0x010..0x013, one extra beat dropped silently.
        exp_cmpl = 1;
        do_init(9'h010, 9'd0, 9'd4);
        chk("basic_busy", 64'(busy), 64'd1);
        chk("basic_wr_en_before_beat", 64'(wr_en), 64'd0);
        for (int i = 0; i < 4; i++) begin
            beat(32'h100 * (2 * i + 1), 32'h100 * (2 * i + 2), 1'b1, 9'(9'h010 + i));
            if (i == 0) begin
                chk("basic_wr_en_next_cycle", 64'(wr_en), 64'd1);
                chk("basic_first_addr", 64'(wr_addr), 64'h010);
            end
        end
        beat(32'h0000DEAD, 32'h0000BEEF, 1'b0, 9'h000);
        drain("basic", 20);
        chk("basic_overflow", 64'(overflow), 64'd0);
        chk("basic_busy_end", 64'(busy), 64'd0);

        // Backpressure: three stalled cycles during a 4-beat burst.
        exp_cmpl = 1;
        do_init(9'h020, 9'd0, 9'd4);
        beat(32'h11111111, 32'h22222222, 1'b1, 9'h020);
        wr_ready = 1'b0;
        beat(32'h33333333, 32'h44444444, 1'b1, 9'h021);
        beat(32'h55555555, 32'h66666666, 1'b1, 9'h022);
        beat(32'h77777777, 32'h08888888, 1'b1, 9'h023);
        chk("bp_addr_held", 64'(wr_addr), 64'h020);
        wr_ready = 1'b1;
        drain("backpressure", 20);
        chk("bp_overflow", 64'(overflow), 64'd0);

        // Overflow: 6 beats into a 4-deep buffer with the memory stalled.
        exp_cmpl = 0;
        do_init(9'h040, 9'd0, 9'd8);
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            beat(32'hA0 + 32'(i), 32'hB0 + 32'(i), (i < 4), 9'(9'h040 + i));
        end
        chk("ovf_flag", 64'(overflow), 64'd1);
        wr_ready = 1'b1;
        drain("ovf_first4", 20);
        chk("ovf_still_busy", 64'(busy), 64'd1);
        do_init(9'h100, 9'd0, 9'd1);
        chk("ovf_init_ignored_busy", 64'(busy), 64'd1);
        chk("ovf_init_ignored_flag", 64'(overflow), 64'd1);
        exp_cmpl = 1;
        for (int i = 0; i < 4; i++) begin
            beat(32'hC0 + 32'(i), 32'hD0 + 32'(i), 1'b1, 9'(9'h044 + i));
        end
        drain("ovf_rest", 20);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Address wrap, then a zero-count init.
        exp_cmpl = 1;
        do_init(9'h1FF, 9'd5, 9'd7);
        chk("wrap_ovf_cleared", 64'(overflow), 64'd0);
        beat(32'h0000AAAA, 32'h0000BBBB, 1'b1, 9'h1FF);
        beat(32'h0000CCCC, 32'h0000DDDD, 1'b1, 9'h000);
        drain("wrap", 20);
        zero_mode = 1'b1;
        exp_cmpl  = 1;
        do_init(9'h055, 9'd3, 9'd3);
        chk("zero_complete", 64'(complete), 64'd1);
        chk("zero_wr_en", 64'(wr_en), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);
        tick();
        chk("zero_complete_pulse", 64'(complete), 64'd0);
        drain("zero", 5);
        zero_mode = 1'b0;

        // Reset after two of the writes.
        exp_cmpl = 0;
        do_init(9'h080, 9'd0, 9'd4);
        beat(32'h00000E01, 32'h00000F01, 1'b1, 9'h080);
        beat(32'h00000E02, 32'h00000F02, 1'b1, 9'h081);
        beat(32'h00000E03, 32'h00000F03, 1'b0, 9'h000);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrun");
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("midrun_idle_busy", 64'(busy), 64'd0);
        chk("midrun_no_pending", 64'(exp_q.size()), 64'd0);

        // Negative lane: clamped to zero only when the clamp macro is defined.
        exp_cmpl = 1;
        do_init(9'h0A0, 9'd0, 9'd1);
        beat(32'h80000010, 32'h00000020, 1'b1, 9'h0A0);
`ifdef SMAX_OUT_CLAMP_EN
        chk("clamp_lane0", 64'(wr_data[31:0]), 64'h0);
`else
        chk("clamp_lane0", 64'(wr_data[31:0]), 64'h80000010);
`endif
        drain("clamp", 20);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
